// File: rtl/bmul_acc_if.sv
// Handshake/bus bundle between the bmul product stream, bmul_acc and the result consumer.
// The master is the surrounding logic; the slave is bmul_acc.
interface bmul_acc_if;
    logic       clr;
    logic [7:0] prod_int1;
    logic [7:0] prod_int2;
    logic [7:0] prod_dec1;
    logic [7:0] prod_dec2;
    logic       prod_rdy;
    logic [7:0] out_int;
    logic [7:0] out_dec;
    logic       out_rdy;
    logic       out_ack;
    logic       sat;
    logic       ovr;
    logic       busy;

    modport master (
        output clr, prod_int1, prod_int2, prod_dec1, prod_dec2, prod_rdy, out_ack,
        input  out_int, out_dec, out_rdy, sat, ovr, busy
    );

    modport slave (
        input  clr, prod_int1, prod_int2, prod_dec1, prod_dec2, prod_rdy, out_ack,
        output out_int, out_dec, out_rdy, sat, ovr, busy
    );
endinterface

// File: rtl/bmul_acc.sv
// Accumulates NUM_TERMS unsigned 16.16 products, rounds/saturates to Q8.8, rdy/ack output.
// Define BMUL_ACC_RND_EN for round-half-up; otherwise the result is truncated.
module bmul_acc #(
    parameter int unsigned NUM_TERMS = 4,
    parameter int unsigned CNT_W     = 8
) (
    input logic       clk,
    input logic       rst,
    bmul_acc_if.slave bus
);
    localparam int unsigned ACC_W = 32 + CNT_W;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_TERMS);

    typedef enum logic [1:0] {StIdle, StAcc, StRound, StHold} state_e;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        out_q, out_d;
    logic               sat_q, sat_d;
    logic               out_rdy_q, out_rdy_d;
    logic               ovr_q, ovr_d;

    logic [31:0]        prod;
    logic [CNT_W-1:0]   cnt_inc;
    logic [ACC_W:0]     rnd_sum;
    logic [ACC_W-8:0]   r;
    logic               r_big;

    assign prod    = {bus.prod_int1, bus.prod_int2, bus.prod_dec1, bus.prod_dec2};
    assign cnt_inc = cnt_q + 1'b1;

`ifdef BMUL_ACC_RND_EN
    assign rnd_sum = {1'b0, acc_q} + (ACC_W + 1)'(8'h80);
`else
    assign rnd_sum = {1'b0, acc_q};
`endif
    assign r     = rnd_sum[ACC_W:8];
    assign r_big = |r[ACC_W-8:16];

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        out_d     = out_q;
        sat_d     = sat_q;
        out_rdy_d = out_rdy_q;
        ovr_d     = ovr_q;
        if (bus.clr) begin
            // Abort wins over everything; the last result stays visible.
            state_d   = StIdle;
            acc_d     = '0;
            cnt_d     = '0;
            out_rdy_d = 1'b0;
            ovr_d     = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.prod_rdy) begin
                        acc_d   = ACC_W'(prod);
                        cnt_d   = CNT_W'(1);
                        state_d = (NUM_TERMS == 1) ? StRound : StAcc;
                    end
                end
                StAcc: begin
                    if (bus.prod_rdy) begin
                        acc_d = acc_q + ACC_W'(prod);
                        cnt_d = cnt_inc;
                        if (cnt_inc == LAST_CNT) begin
                            state_d = StRound;
                        end
                    end
                end
                StRound: begin
                    if (bus.prod_rdy) begin
                        ovr_d = 1'b1;
                    end
                    out_d     = r_big ? 16'hFFFF : r[15:0];
                    sat_d     = r_big;
                    out_rdy_d = 1'b1;
                    state_d   = StHold;
                end
                StHold: begin
                    // A product coinciding with the releasing ack is still dropped.
                    if (bus.prod_rdy) begin
                        ovr_d = 1'b1;
                    end
                    if (bus.out_ack) begin
                        out_rdy_d = 1'b0;
                        acc_d     = '0;
                        cnt_d     = '0;
                        state_d   = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            cnt_q     <= '0;
            out_q     <= '0;
            sat_q     <= 1'b0;
            out_rdy_q <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            sat_q     <= sat_d;
            out_rdy_q <= out_rdy_d;
            ovr_q     <= ovr_d;
        end
    end

    assign bus.out_int = out_q[15:8];
    assign bus.out_dec = out_q[7:0];
    assign bus.sat     = sat_q;
    assign bus.out_rdy = out_rdy_q;
    assign bus.ovr     = ovr_q;
    assign bus.busy    = (state_q != StIdle);
endmodule

// File: doc/bmul_acc.md
Name: bmul_acc

Overview:
- Downstream stage of the bit-serial fixed-point multiplier (bmul).
- Consumes each unsigned 16.16 product, delivered as four bytes with a res_rdy-style pulse.
- Accumulates NUM_TERMS products, then rounds and saturates the sum back to Q8.8.
- Presents the result to the next stage on a rdy/ack handshake. This makes the multiplier usable as a dot-product / MAC engine.

Parameters:
NUM_TERMS, 4, products summed per result (1..255)
CNT_W, 8, width of term counter (must satisfy 2^CNT_W > NUM_TERMS)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-high reset
clr  input  1  synchronous abort: discard partial sum, clear ovr, return to IDLE
prod_int1  input  8  product bits [31:24]
prod_int2  input  8  product bits [23:16]
prod_dec1  input  8  product bits [15:8]
prod_dec2  input  8  product bits [7:0]
prod_rdy  input  1  one-cycle pulse: product bytes valid this cycle
out_int  output  8  Q8.8 result integer byte
out_dec  output  8  Q8.8 result fraction byte
out_rdy  output  1  result valid, held until out_ack
out_ack  input  1  consumer accepts result
sat  output  1  result was clamped to 0xFFFF; valid with out_rdy
ovr  output  1  sticky: a product arrived while not accepting
busy  output  1  high whenever state != IDLE

Behaviour:
- Clock and reset:
  - One clock, clk. Reset rst is asynchronous and active-high.
  - On rst: state=IDLE, acc=0, cnt=0, out_int=0, out_dec=0, out_rdy=0, sat=0, ovr=0, busy=0.
  - rst mid-operation discards everything; no output is produced.
- Arithmetic:
  - All arithmetic is unsigned. Product P = {prod_int1, prod_int2, prod_dec1, prod_dec2}.
  - Accumulator acc is 32+CNT_W bits wide and never wraps.
- State IDLE:
  - prod_rdy: acc<=P, cnt<=1, go to ACC (or ROUND if NUM_TERMS==1).
- State ACC:
  - prod_rdy: acc<=acc+P, cnt<=cnt+1.
  - When the accepted term makes cnt==NUM_TERMS, go to ROUND next cycle.
- State ROUND (exactly one cycle):
  - r = (acc + 0x80) >> 8.
  - If r > 0xFFFF: out = 0xFFFF and sat=1; else out = r[15:0] and sat=0.
  - Register out_int, out_dec and sat; set out_rdy=1; go to HOLD.
- State HOLD:
  - out_rdy stays 1 and outputs stay stable until out_ack.
  - On out_ack: out_rdy<=0, acc<=0, cnt<=0, go to IDLE.
  - out_int, out_dec and sat keep their last value after the handshake.
- Latency: result out_rdy rises 2 cycles after the prod_rdy pulse of the last term.
- Overrun:
  - prod_rdy in ROUND or HOLD is dropped and sets ovr=1.
  - ovr clears only on clr or rst.
  - prod_rdy in the same cycle as the out_ack that releases HOLD is also dropped (ovr=1).
- clr:
  - Has priority over prod_rdy and out_ack in the same cycle.
  - Forces IDLE, acc=0, cnt=0, out_rdy=0, ovr=0.
  - out_int, out_dec and sat are unchanged.
- out_ack outside HOLD is ignored.

Optional Feature:
- Macro: BMUL_ACC_RND_EN.
- Defined: ROUND applies round-half-up, r = (acc + 0x80) >> 8.
- Undefined: ROUND truncates, r = acc >> 8. Saturation, latency and handshake are unchanged.

Test Plan:
- NUM_TERMS=4, four prod_rdy pulses with P=0x00010000 (1.0), out_ack held 1 -> out_rdy two cycles after 4th pulse, out_int=0x04, out_dec=0x00, sat=0, busy low after ack.
- NUM_TERMS=1, P=0x00000080 -> out={0x00,0x01} with BMUL_ACC_RND_EN; {0x00,0x00} without. Also P=0x0000007F -> {0x00,0x00} in both builds.
- NUM_TERMS=4, four P=0xFFFF0000 -> out_int=0xFF, out_dec=0xFF, sat=1.
- NUM_TERMS=2, two products, out_ack held 0 for 5 cycles with a prod_rdy during HOLD -> outputs stable, ovr=1. After out_ack, next two P=0x00000100 -> out={0x00,0x02}, ovr still 1 until clr.
- NUM_TERMS=4, two products then rst pulse mid-cycle (async) -> all outputs 0 immediately. Repeat with clr instead: IDLE next cycle, subsequent 4 terms of 0x00010000 -> {0x04,0x00} with no residue.
- clr and prod_rdy in same cycle in ACC -> product dropped, cnt=0, acc=0, ovr=0.
